// File: rtl/lock_pkg.sv
// Shared state encodings, counter widths and helpers for the lock attempt controller.
package lock_pkg;

   localparam int unsigned TIMER_W = 32;
   localparam int unsigned TRY_W   = 3;

   typedef enum logic [2:0] {
      ST_ARMED   = 3'd0,
      ST_CLEAR   = 3'd1,
      ST_OPEN    = 3'd2,
      ST_LOCKOUT = 3'd3
   } lock_state_t;

   // Saturating increment so a stuck FsmFail cannot wrap the try count back to zero.
   function automatic logic [TRY_W-1:0] sat_inc(input logic [TRY_W-1:0] v);
      return (v == {TRY_W{1'b1}}) ? v : v + TRY_W'(1);
   endfunction

endpackage

// File: rtl/key_edge_detect.sv
// Rising-edge detector for one synchronized button level.
module key_edge_detect (
   input  logic clk,
   input  logic rst,
   input  logic key,
   output logic rise_c
);

   logic prev;

   always_ff @(posedge clk) begin
      if (rst) prev <= 1'b0;
      else     prev <= key;
   end

   assign rise_c = key & ~prev;

endmodule

// File: rtl/lock_attempt_ctrl.sv
// Attempt limiter in front of the combination-lock FSM: key pulsing, lockout and auto-relock.
// Optional LOCK_PW_PROGRAM_EN: a Key2 event while open reprograms the presented password.
module lock_attempt_ctrl
   import lock_pkg::*;
#(
   parameter int unsigned MAX_TRIES      = 3,
   parameter int unsigned LOCKOUT_CYCLES = 500_000_000,
   parameter int unsigned OPEN_CYCLES    = 1_000_000_000,
   parameter logic [3:0]  DEFAULT_PW     = 4'b1010
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       Key1,
   input  logic       Key2,
   input  logic [3:0] Password,
   input  logic       FsmOpen,
   input  logic       FsmFail,
   output logic       KeyOut1,
   output logic       KeyOut2,
   output logic       FsmReset,
   output logic [3:0] PwOut,
   output logic       Unlocked,
   output logic [2:0] State
);

   localparam logic [TIMER_W-1:0] OPEN_LOAD = TIMER_W'(OPEN_CYCLES - 1);
   localparam logic [TIMER_W-1:0] LOCK_LOAD = TIMER_W'(LOCKOUT_CYCLES - 1);
   localparam logic [TRY_W-1:0]   TRY_MAX   = TRY_W'(MAX_TRIES);

   lock_state_t        state_q, state_n;
   logic [TIMER_W-1:0] timer_q, timer_n;
   logic [TRY_W-1:0]   tries_q, tries_n, tries_inc;
   logic               k1_c, k2_c;
   logic               pulse1_c, pulse2_c;

   key_edge_detect u_edge1 (.clk(Clk), .rst(Reset), .key(Key1), .rise_c(k1_c));
   key_edge_detect u_edge2 (.clk(Clk), .rst(Reset), .key(Key2), .rise_c(k2_c));

   // Next state, shared timer and try counter.
   always_comb begin
      state_n   = state_q;
      timer_n   = timer_q;
      tries_n   = tries_q;
      tries_inc = sat_inc(tries_q);
      case (state_q)
         ST_ARMED: begin
            if (FsmFail) begin
               tries_n = tries_inc;
               if (tries_inc == TRY_MAX) begin
                  state_n = ST_LOCKOUT;
                  timer_n = LOCK_LOAD;
               end else begin
                  state_n = ST_CLEAR;
               end
            end else if (FsmOpen) begin
               state_n = ST_OPEN;
               tries_n = '0;
               timer_n = OPEN_LOAD;
            end
         end
         ST_CLEAR: state_n = ST_ARMED;
         ST_OPEN: begin
            if (k1_c || timer_q == '0) state_n = ST_CLEAR;
            else                       timer_n = timer_q - TIMER_W'(1);
         end
         ST_LOCKOUT: begin
            if (timer_q == '0) begin
               state_n = ST_CLEAR;
               tries_n = '0;
            end else begin
               timer_n = timer_q - TIMER_W'(1);
            end
         end
         default: state_n = ST_CLEAR;
      endcase
   end

   // Simultaneous key edges cancel; pulses only while armed and staying armed.
   assign pulse1_c = (state_q == ST_ARMED) && (state_n == ST_ARMED) && k1_c && !k2_c;
   assign pulse2_c = (state_q == ST_ARMED) && (state_n == ST_ARMED) && k2_c && !k1_c;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q  <= ST_CLEAR;
         timer_q  <= '0;
         tries_q  <= '0;
         KeyOut1  <= 1'b0;
         KeyOut2  <= 1'b0;
         Unlocked <= 1'b0;
         FsmReset <= 1'b1;
         State    <= 3'(ST_CLEAR);
      end else begin
         state_q  <= state_n;
         timer_q  <= timer_n;
         tries_q  <= tries_n;
         KeyOut1  <= pulse1_c;
         KeyOut2  <= pulse2_c;
         Unlocked <= (state_n == ST_OPEN);
         FsmReset <= (state_n == ST_CLEAR) || (state_n == ST_LOCKOUT);
         State    <= 3'(state_n);
      end
   end

`ifdef LOCK_PW_PROGRAM_EN
   logic [3:0] pw_q;

   // Programmed password persists through lockouts; only Reset restores the default.
   always_ff @(posedge Clk) begin
      if (Reset)                              pw_q <= DEFAULT_PW;
      else if (state_q == ST_OPEN && k2_c)    pw_q <= Password;
   end

   assign PwOut = pw_q;
`else
   logic unused_pw;

   assign unused_pw = ^Password;
   assign PwOut     = DEFAULT_PW;
`endif

endmodule

// File: tb/tb_lock_attempt_ctrl.sv
// Scoreboard bench for lock_attempt_ctrl: expected per-cycle outputs queued with each stimulus.
module tb_lock_attempt_ctrl;

   localparam logic [2:0] ARM = 3'd0, CLR = 3'd1, OPN = 3'd2, LCK = 3'd3;
   localparam logic [3:0] PW_DEF = 4'b1010, PW_NEW = 4'b0110;

   logic       Clk = 1'b0;
   logic       Reset, Key1, Key2, FsmOpen, FsmFail;
   logic [3:0] Password;
   logic       KeyOut1, KeyOut2, FsmReset, Unlocked;
   logic [3:0] PwOut;
   logic [2:0] State;

   always #5 Clk = ~Clk;

   lock_attempt_ctrl #(
      .MAX_TRIES(3), .LOCKOUT_CYCLES(10), .OPEN_CYCLES(8), .DEFAULT_PW(PW_DEF)
   ) dut (
      .Clk(Clk), .Reset(Reset), .Key1(Key1), .Key2(Key2), .Password(Password),
      .FsmOpen(FsmOpen), .FsmFail(FsmFail), .KeyOut1(KeyOut1), .KeyOut2(KeyOut2),
      .FsmReset(FsmReset), .PwOut(PwOut), .Unlocked(Unlocked), .State(State)
   );

   typedef struct packed { logic rst, k1, k2, fo, ff; logic [3:0] pw; } stim_t;
   typedef struct { string tag; logic [10:0] v; } exp_t;

   stim_t      stim_q[$];
   exp_t       exp_q[$];
   logic [3:0] pw_exp = PW_DEF;
   int         n_tests = 0;
   int         n_fail  = 0;

   function automatic stim_t S(logic rst, logic k1, logic k2, logic fo, logic ff,
                               logic [3:0] pw = 4'b0000);
      S = '{rst: rst, k1: k1, k2: k2, fo: fo, ff: ff, pw: pw};
   endfunction

   // Expected {State, Unlocked, KeyOut1, KeyOut2, FsmReset, PwOut}.
   function automatic logic [10:0] E(logic [2:0] st, logic unl, logic ko1, logic ko2, logic fr);
      E = {st, unl, ko1, ko2, fr, pw_exp};
   endfunction

   function automatic void sc(string tag, stim_t s, logic [10:0] e);
      exp_t x;
      x.tag = tag;
      x.v   = e;
      stim_q.push_back(s);
      exp_q.push_back(x);
   endfunction

   task automatic apply(input stim_t s);
      Reset    = s.rst;
      Key1     = s.k1;
      Key2     = s.k2;
      FsmOpen  = s.fo;
      FsmFail  = s.ff;
      Password = s.pw;
      @(negedge Clk);
   endtask

   task automatic test_reset;
      exp_t e;
      logic [10:0] got;
      sc("rst_state", S(1,0,0,0,0), E(CLR,0,0,0,1));
      sc("rst_override", S(1,1,1,1,1), E(CLR,0,0,0,1));
      sc("rel_armed", S(0,0,0,0,0), E(ARM,0,0,0,0));
      while (stim_q.size() != 0) begin
         apply(stim_q.pop_front());
         e = exp_q.pop_front();
         got = {State, Unlocked, KeyOut1, KeyOut2, FsmReset, PwOut};
         n_tests++;
         if (got !== e.v) begin
            n_fail++;
            $display("FAIL %s: got %03h expected %03h", e.tag, got, e.v);
         end
      end
   endtask

   task automatic test_key_pulse;
      exp_t e;
      logic [10:0] got;
      sc("k1_pulse", S(0,1,0,0,0), E(ARM,0,1,0,0));
      sc("k1_held", S(0,1,0,0,0), E(ARM,0,0,0,0));
      sc("k1_rel", S(0,0,0,0,0), E(ARM,0,0,0,0));
      sc("k2_pulse", S(0,0,1,0,0), E(ARM,0,0,1,0));
      sc("k2_rel", S(0,0,0,0,0), E(ARM,0,0,0,0));
      while (stim_q.size() != 0) begin
         apply(stim_q.pop_front());
         e = exp_q.pop_front();
         got = {State, Unlocked, KeyOut1, KeyOut2, FsmReset, PwOut};
         n_tests++;
         if (got !== e.v) begin
            n_fail++;
            $display("FAIL %s: got %03h expected %03h", e.tag, got, e.v);
         end
      end
   endtask

   task automatic test_simul_keys;
      exp_t e;
      logic [10:0] got;
      sc("both_edges", S(0,1,1,0,0), E(ARM,0,0,0,0));
      sc("both_held", S(0,1,1,0,0), E(ARM,0,0,0,0));
      sc("k1_drop", S(0,0,1,0,0), E(ARM,0,0,0,0));
      sc("k1_alone", S(0,1,1,0,0), E(ARM,0,1,0,0));
      sc("both_rel", S(0,0,0,0,0), E(ARM,0,0,0,0));
      while (stim_q.size() != 0) begin
         apply(stim_q.pop_front());
         e = exp_q.pop_front();
         got = {State, Unlocked, KeyOut1, KeyOut2, FsmReset, PwOut};
         n_tests++;
         if (got !== e.v) begin
            n_fail++;
            $display("FAIL %s: got %03h expected %03h", e.tag, got, e.v);
         end
      end
   endtask

   task automatic test_open;
      exp_t e;
      logic [10:0] got;
      for (int i = 0; i < 2; i++) begin
         sc("pre_fail", S(0,0,0,0,1), E(CLR,0,0,0,1));
         sc("pre_arm", S(0,0,0,0,0), E(ARM,0,0,0,0));
      end
      sc("open_enter", S(0,0,0,1,0), E(OPN,1,0,0,0));
      for (int i = 0; i < 7; i++) sc("open_hold", S(0,0,0,0,0), E(OPN,1,0,0,0));
      sc("open_expire", S(0,0,0,0,0), E(CLR,0,0,0,1));
      sc("open_rearm", S(0,0,0,0,0), E(ARM,0,0,0,0));
      sc("tries_cleared", S(0,0,0,0,1), E(CLR,0,0,0,1));
      sc("tries_rearm", S(0,0,0,0,0), E(ARM,0,0,0,0));
      // Early relock on Key1.
      sc("open2_enter", S(0,0,0,1,0), E(OPN,1,0,0,0));
      sc("open2_key1", S(0,1,0,0,0), E(CLR,0,0,0,1));
      sc("open2_rearm", S(0,0,0,0,0), E(ARM,0,0,0,0));
      while (stim_q.size() != 0) begin
         apply(stim_q.pop_front());
         e = exp_q.pop_front();
         got = {State, Unlocked, KeyOut1, KeyOut2, FsmReset, PwOut};
         n_tests++;
         if (got !== e.v) begin
            n_fail++;
            $display("FAIL %s: got %03h expected %03h", e.tag, got, e.v);
         end
      end
   endtask

   task automatic test_simul_fsm;
      exp_t e;
      logic [10:0] got;
      for (int i = 0; i < 2; i++) begin
         sc("of_both", S(0,0,0,1,1), E(CLR,0,0,0,1));
         sc("of_arm", S(0,0,0,0,0), E(ARM,0,0,0,0));
      end
      sc("of_lock", S(0,0,0,1,1), E(LCK,0,0,0,1));
      for (int i = 0; i < 9; i++) sc("of_lock_hold", S(0,0,0,0,0), E(LCK,0,0,0,1));
      sc("of_lock_end", S(0,0,0,0,0), E(CLR,0,0,0,1));
      sc("of_rearm", S(0,0,0,0,0), E(ARM,0,0,0,0));
      while (stim_q.size() != 0) begin
         apply(stim_q.pop_front());
         e = exp_q.pop_front();
         got = {State, Unlocked, KeyOut1, KeyOut2, FsmReset, PwOut};
         n_tests++;
         if (got !== e.v) begin
            n_fail++;
            $display("FAIL %s: got %03h expected %03h", e.tag, got, e.v);
         end
      end
   endtask

   task automatic test_lockout;
      exp_t e;
      logic [10:0] got;
      for (int i = 0; i < 2; i++) begin
         sc("lk_fail", S(0,0,0,0,1), E(CLR,0,0,0,1));
         sc("lk_arm", S(0,0,0,0,0), E(ARM,0,0,0,0));
      end
      sc("lk_enter", S(0,0,0,0,1), E(LCK,0,0,0,1));
      for (int i = 0; i < 9; i++)
         sc("lk_keys_ignored", S(0, logic'(i % 2 == 0), logic'(i % 3 == 0), 0, 0), E(LCK,0,0,0,1));
      sc("lk_exit", S(0,0,0,0,0), E(CLR,0,0,0,1));
      sc("lk_rearm", S(0,0,0,0,0), E(ARM,0,0,0,0));
      for (int i = 0; i < 2; i++) begin
         sc("lk2_fail", S(0,0,0,0,1), E(CLR,0,0,0,1));
         sc("lk2_arm", S(0,0,0,0,0), E(ARM,0,0,0,0));
      end
      sc("lk2_relock", S(0,0,0,0,1), E(LCK,0,0,0,1));
      for (int i = 0; i < 3; i++) sc("lk2_hold", S(0,0,0,0,0), E(LCK,0,0,0,1));
      sc("rst_mid_lock", S(1,0,0,0,0), E(CLR,0,0,0,1));
      sc("rst_rearm", S(0,0,0,0,0), E(ARM,0,0,0,0));
      for (int i = 0; i < 2; i++) begin
         sc("lk3_fail", S(0,0,0,0,1), E(CLR,0,0,0,1));
         sc("lk3_arm", S(0,0,0,0,0), E(ARM,0,0,0,0));
      end
      sc("tries_zero_after_rst", S(0,0,0,0,1), E(LCK,0,0,0,1));
      sc("lk3_rst", S(1,0,0,0,0), E(CLR,0,0,0,1));
      sc("lk3_rearm", S(0,0,0,0,0), E(ARM,0,0,0,0));
      while (stim_q.size() != 0) begin
         apply(stim_q.pop_front());
         e = exp_q.pop_front();
         got = {State, Unlocked, KeyOut1, KeyOut2, FsmReset, PwOut};
         n_tests++;
         if (got !== e.v) begin
            n_fail++;
            $display("FAIL %s: got %03h expected %03h", e.tag, got, e.v);
         end
      end
   endtask

   task automatic test_pw;
      exp_t e;
      logic [10:0] got;
      sc("pw_open", S(0,0,0,1,0), E(OPN,1,0,0,0));
`ifdef LOCK_PW_PROGRAM_EN
      pw_exp = PW_NEW;
`endif
      sc("pw_key2", S(0,0,1,0,0,PW_NEW), E(OPN,1,0,0,0));
      sc("pw_hold", S(0,0,0,0,0), E(OPN,1,0,0,0));
      sc("pw_close", S(0,1,0,0,0), E(CLR,0,0,0,1));
      sc("pw_arm", S(0,0,0,0,0), E(ARM,0,0,0,0));
      for (int i = 0; i < 2; i++) begin
         sc("pw_fail", S(0,0,0,0,1), E(CLR,0,0,0,1));
         sc("pw_fail_arm", S(0,0,0,0,0), E(ARM,0,0,0,0));
      end
      sc("pw_lock", S(0,0,0,0,1), E(LCK,0,0,0,1));
      for (int i = 0; i < 9; i++) sc("pw_lock_hold", S(0,0,0,0,0), E(LCK,0,0,0,1));
      sc("pw_lock_end", S(0,0,0,0,0), E(CLR,0,0,0,1));
      sc("pw_after_lock", S(0,0,0,0,0), E(ARM,0,0,0,0));
      pw_exp = PW_DEF;
      sc("pw_reset", S(1,0,0,0,0), E(CLR,0,0,0,1));
      sc("pw_reset_arm", S(0,0,0,0,0), E(ARM,0,0,0,0));
      while (stim_q.size() != 0) begin
         apply(stim_q.pop_front());
         e = exp_q.pop_front();
         got = {State, Unlocked, KeyOut1, KeyOut2, FsmReset, PwOut};
         n_tests++;
         if (got !== e.v) begin
            n_fail++;
            $display("FAIL %s: got %03h expected %03h", e.tag, got, e.v);
         end
      end
   endtask

   initial begin
      Reset    = 1'b1;
      Key1     = 1'b0;
      Key2     = 1'b0;
      FsmOpen  = 1'b0;
      FsmFail  = 1'b0;
      Password = 4'b0000;
      test_reset();
      test_key_pulse();
      test_simul_keys();
      test_open();
      test_simul_fsm();
      test_lockout();
      test_pw();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
